uart_txrx_core: RTL and testbench
=================================

Name: uart_txrx_core

Overview:
- Serial datapath of a 16550-style UART: a transmit FIFO and serializer plus a receive deserializer and FIFO, under one clock.
- Sits below the register/bus block, which supplies line control, a 16x-baud tick and FIFO push/pop strobes.
- Reports FIFO counts, per-character error flags and a character-timeout counter back to that block.

Parameters:
- FIFO_DEPTH, 16, entries in each FIFO (power of 2).
- CNT_W, 5, FIFO counter width (log2(FIFO_DEPTH)+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- wb_rst_ni  in  1  reset, asynchronous, active-low; one clock domain.
- lcr  in  8  line control: [1:0] word length 5..8 bits; [2] 2 stop bits; [3] parity enable; [4] even parity; [5] stick parity; [6] break control.
- enable  in  1  16x baud tick, one clk wide.
- tf_push  in  1  write wb_dat_i into TX FIFO.
- wb_dat_i  in  8  TX data.
- tx_reset  in  1  synchronous flush of TX FIFO.
- stx_pad_o  out  1  serial TX line, idle 1.
- tstate  out  3  TX state.
- tf_count  out  CNT_W  TX FIFO occupancy.
- rf_pop  in  1  discard RX FIFO head.
- srx_pad_i  in  1  serial RX line.
- rx_reset  in  1  synchronous flush of RX FIFO and overrun.
- lsr_mask  in  1  LSR read pulse; clears overrun.
- counter_t  out  10  character-timeout counter.
- rf_count  out  CNT_W  RX FIFO occupancy.
- rf_data_out  out  11  RX head: [10:3] data, [2] break, [1] parity error, [0] framing error.
- rf_error_bit  out  1  any valid RX entry has bit 2, 1 or 0 set.
- rf_overrun  out  1  char arrived while RX FIFO full; sticky.
- rstate  out  4  RX state.
- rf_push  out  1  one-cycle pulse when a char is written to RX FIFO.

Behaviour:
- Reset: stx_pad_o=1; tstate=0; rstate=0; all counts 0; rf_overrun=0; rf_push=0; counter_t=0; FIFO pointers 0.
- Bit time: 16 enable ticks; nothing advances without enable.
- TX states: 0 idle, 1 start, 2 data, 3 parity, 4 stop.
  - Idle with tf_count>0 pops the FIFO head into the shifter and enters start.
  - Data bits are sent LSB first, 5..8 per lcr[1:0].
  - Parity is sent only if lcr[3]: even/odd per lcr[4]; when lcr[5]=1 the parity bit is ~lcr[4].
  - Stop is 1 bit, or 2 if lcr[2]; then return to idle.
  - lcr[6]=1 forces stx_pad_o=0 without altering the state machine.
- TX FIFO:
  - Push while full is dropped.
  - Push and pop in the same cycle leave the count unchanged.
  - tx_reset zeroes the FIFO; a character already in the shifter completes.
- RX states: 0 idle, 1 start, 2 data, 3 parity, 4 stop, 5 push.
  - Idle detects srx_pad_i=0 and enters start.
  - Sampling is at the 8th tick of each bit; start sampled 1 means a glitch and a return to idle.
  - Data is captured LSB first and zero-extended to 8 bits.
  - Parity is checked if lcr[3].
  - Only the first stop bit is checked; stop=0 sets the framing error.
  - Break: data, parity and stop all 0 sets break and framing error.
  - Push state writes the 11-bit entry and pulses rf_push for one cycle, then returns to idle.
- RX FIFO:
  - Push while full does not store and sets rf_overrun.
  - rf_overrun clears on lsr_mask or rx_reset.
  - rf_pop on empty is ignored.
  - rf_data_out is combinational from the head; it is 0 when empty.
  - rx_reset flushes the FIFO; rx_reset has priority over a simultaneous push.
- counter_t:
  - Reload value = 64 x character bits, where character bits = start+data+parity+stops, max 768.
  - Reload on rf_push, on rf_pop, or while rf_count=0.
  - Otherwise decrement on each enable, saturating at 0.
  - 0 with data present means timeout.

Test Plan:
- Reset, then lcr=0x03, enable every clk, push 0x55 -> stx_pad_o gives start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 16 ticks; tstate returns 0; tf_count 1->0.
- Loop stx to srx with lcr=0x1B (8E1), send 0xA5 -> rf_push pulse; rf_count=1; rf_data_out=0x528 (data 0xA5, flags 0); rf_error_bit=0.
- Drive a bad parity bit -> rf_data_out[1]=1 and rf_error_bit=1; rf_pop -> rf_count=0 and rf_error_bit=0.
- Hold srx low 12 bit-times -> entry with data 0, break=1, framing=1.
- Receive 17 chars without pop -> rf_count=16 and rf_overrun=1; lsr_mask -> rf_overrun=0.
- 8N1, one char received, no pop -> counter_t reloads to 640 and reaches 0 after 640 ticks; rx_reset -> rf_count=0.

Source files
------------

// File: rtl/uart_txrx_core.sv
// rtl/uart_txrx_core.sv - serial TX/RX datapath of a 16550-style UART
//
// Purpose: transmit FIFO + serializer and receive deserializer + FIFO
// for a 16550-style UART. Everything runs on one clock. Bit timing is
// driven by a 16x-baud enable tick.
//
// Ports:
//   clk, wb_rst_ni       clock, asynchronous active-low reset
//   lcr                  line control (word length, stop bits, parity, break)
//   enable               16x baud tick, one clk wide
//   tf_push, wb_dat_i    TX FIFO write strobe and data
//   tx_reset             synchronous TX FIFO flush
//   stx_pad_o            serial TX line (idle 1)
//   tstate, tf_count     TX state, TX FIFO occupancy
//   rf_pop               discard RX FIFO head
//   srx_pad_i            serial RX line
//   rx_reset             synchronous RX FIFO and overrun flush
//   lsr_mask             LSR read pulse, clears overrun
//   counter_t            character-timeout counter
//   rf_count             RX FIFO occupancy
//   rf_data_out          RX head {data[7:0], break, parity err, framing err}
//   rf_error_bit         some stored RX entry carries an error flag
//   rf_overrun           sticky: character lost because RX FIFO was full
//   rstate, rf_push      RX state, one-cycle RX FIFO write pulse

`timescale 1ns/1ps

module uart_txrx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_store,
   output logic             o_take,
   output logic             o_drop
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_empty;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // A flush overrides any push or pop arriving in the same cycle.
   assign o_store = i_push && !w_full && !i_clear;
   assign o_take  = i_pop && !w_empty && !i_clear;
   assign o_drop  = i_push && w_full && !i_clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (o_store) r_wr <= r_wr + 1'b1;
         if (o_take)  r_rd <= r_rd + 1'b1;
         case ({o_store, o_take})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (o_store) r_mem[r_wr] <= i_data;
   end

   assign o_head  = w_empty ? '0 : r_mem[r_rd];
   assign o_count = r_count;
endmodule

module uart_txrx_core #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 5
) (
   input  logic             clk,
   input  logic             wb_rst_ni,
   input  logic [7:0]       lcr,
   input  logic             enable,
   input  logic             tf_push,
   input  logic [7:0]       wb_dat_i,
   input  logic             tx_reset,
   output logic             stx_pad_o,
   output logic [2:0]       tstate,
   output logic [CNT_W-1:0] tf_count,
   input  logic             rf_pop,
   input  logic             srx_pad_i,
   input  logic             rx_reset,
   input  logic             lsr_mask,
   output logic [9:0]       counter_t,
   output logic [CNT_W-1:0] rf_count,
   output logic [10:0]      rf_data_out,
   output logic             rf_error_bit,
   output logic             rf_overrun,
   output logic [3:0]       rstate,
   output logic             rf_push
);
   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_START = 3'd1,
      TX_DATA  = 3'd2,
      TX_PAR   = 3'd3,
      TX_STOP  = 3'd4
   } tx_state_t;

   typedef enum logic [3:0] {
      RX_IDLE  = 4'd0,
      RX_START = 4'd1,
      RX_DATA  = 4'd2,
      RX_PAR   = 4'd3,
      RX_STOP  = 4'd4,
      RX_PUSH  = 4'd5
   } rx_state_t;

   // Index of the last data bit (4..7 for 5..8 bit words) and data mask.
   logic [2:0] w_last_bit;
   logic [7:0] w_wmask;
   logic [3:0] w_char_bits;
   assign w_last_bit  = {1'b1, lcr[1:0]};
   assign w_wmask     = 8'hFF >> (2'd3 - lcr[1:0]);
   assign w_char_bits = 4'd7 + {2'b00, lcr[1:0]} + {3'b000, lcr[3]} + {3'b000, lcr[2]};

   // ---------------------------------------------------------------- TX
   logic [7:0] w_tf_head;
   logic       w_tf_pop;
   logic       w_tf_store, w_tf_take, w_tf_drop;

   uart_txrx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (wb_rst_ni),
      .i_clear (tx_reset),
      .i_push  (tf_push),
      .i_data  (wb_dat_i),
      .i_pop   (w_tf_pop),
      .o_head  (w_tf_head),
      .o_count (tf_count),
      .o_store (w_tf_store),
      .o_take  (w_tf_take),
      .o_drop  (w_tf_drop)
   );

   tx_state_t  r_tx_state, w_tx_state_nx;
   logic [4:0] r_tx_cnt, w_tx_cnt_nx;
   logic [7:0] r_tx_sh, w_tx_sh_nx;
   logic [2:0] r_tx_bits, w_tx_bits_nx;
   logic       r_tx_par, w_tx_par_nx;
   logic       w_tx_line;
   logic       w_tx_head_xor;
   logic [4:0] w_tx_stop_last;

   assign w_tx_head_xor  = ^(w_tf_head & w_wmask);
   assign w_tx_stop_last = lcr[2] ? 5'd31 : 5'd15;

   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_sh    <= '0;
         r_tx_bits  <= '0;
         r_tx_par   <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nx;
         r_tx_cnt   <= w_tx_cnt_nx;
         r_tx_sh    <= w_tx_sh_nx;
         r_tx_bits  <= w_tx_bits_nx;
         r_tx_par   <= w_tx_par_nx;
      end
   end

   always_comb begin
      w_tx_state_nx = r_tx_state;
      w_tx_cnt_nx   = r_tx_cnt;
      w_tx_sh_nx    = r_tx_sh;
      w_tx_bits_nx  = r_tx_bits;
      w_tx_par_nx   = r_tx_par;
      w_tf_pop      = 1'b0;
      w_tx_line     = 1'b1;
      case (r_tx_state)
         TX_IDLE: begin
            if (enable && (tf_count != '0)) begin
               w_tf_pop      = 1'b1;
               w_tx_sh_nx    = w_tf_head;
               // Stick parity sends ~lcr[4]; even parity makes the one-count even.
               w_tx_par_nx   = lcr[5] ? ~lcr[4] : (lcr[4] ? w_tx_head_xor : ~w_tx_head_xor);
               w_tx_cnt_nx   = '0;
               w_tx_state_nx = TX_START;
            end
         end
         TX_START: begin
            w_tx_line = 1'b0;
            if (enable) begin
               if (r_tx_cnt == 5'd15) begin
                  w_tx_cnt_nx   = '0;
                  w_tx_bits_nx  = '0;
                  w_tx_state_nx = TX_DATA;
               end else begin
                  w_tx_cnt_nx = r_tx_cnt + 5'd1;
               end
            end
         end
         TX_DATA: begin
            w_tx_line = r_tx_sh[0];
            if (enable) begin
               if (r_tx_cnt == 5'd15) begin
                  w_tx_cnt_nx = '0;
                  w_tx_sh_nx  = r_tx_sh >> 1;
                  if (r_tx_bits == w_last_bit) begin
                     w_tx_state_nx = lcr[3] ? TX_PAR : TX_STOP;
                  end else begin
                     w_tx_bits_nx = r_tx_bits + 3'd1;
                  end
               end else begin
                  w_tx_cnt_nx = r_tx_cnt + 5'd1;
               end
            end
         end
         TX_PAR: begin
            w_tx_line = r_tx_par;
            if (enable) begin
               if (r_tx_cnt == 5'd15) begin
                  w_tx_cnt_nx   = '0;
                  w_tx_state_nx = TX_STOP;
               end else begin
                  w_tx_cnt_nx = r_tx_cnt + 5'd1;
               end
            end
         end
         TX_STOP: begin
            w_tx_line = 1'b1;
            if (enable) begin
               if (r_tx_cnt == w_tx_stop_last) begin
                  w_tx_cnt_nx   = '0;
                  w_tx_state_nx = TX_IDLE;
               end else begin
                  w_tx_cnt_nx = r_tx_cnt + 5'd1;
               end
            end
         end
         default: begin
            w_tx_cnt_nx   = '0;
            w_tx_state_nx = TX_IDLE;
         end
      endcase
   end

   // Break control overrides the line only; the serializer keeps running.
   assign stx_pad_o = lcr[6] ? 1'b0 : w_tx_line;
   assign tstate    = r_tx_state;

   // ---------------------------------------------------------------- RX
   rx_state_t  r_rx_state, w_rx_state_nx;
   logic [3:0] r_rx_cnt, w_rx_cnt_nx;
   logic [7:0] r_rx_sh, w_rx_sh_nx;
   logic [2:0] r_rx_bits, w_rx_bits_nx;
   logic       r_rx_zero, w_rx_zero_nx;
   logic       r_rx_perr, w_rx_perr_nx;
   logic       r_rx_ferr, w_rx_ferr_nx;
   logic       r_rx_brk, w_rx_brk_nx;
   logic       w_rx_exp_par;
   logic [10:0] w_rx_entry;

   assign w_rx_exp_par = lcr[5] ? ~lcr[4] : (lcr[4] ? ^r_rx_sh : ~^r_rx_sh);
   assign w_rx_entry   = {r_rx_sh, r_rx_brk, r_rx_perr, r_rx_ferr};

   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_sh    <= '0;
         r_rx_bits  <= '0;
         r_rx_zero  <= 1'b0;
         r_rx_perr  <= 1'b0;
         r_rx_ferr  <= 1'b0;
         r_rx_brk   <= 1'b0;
      end else begin
         r_rx_state <= w_rx_state_nx;
         r_rx_cnt   <= w_rx_cnt_nx;
         r_rx_sh    <= w_rx_sh_nx;
         r_rx_bits  <= w_rx_bits_nx;
         r_rx_zero  <= w_rx_zero_nx;
         r_rx_perr  <= w_rx_perr_nx;
         r_rx_ferr  <= w_rx_ferr_nx;
         r_rx_brk   <= w_rx_brk_nx;
      end
   end

   // Each bit is sampled at tick 7 of its 16-tick window. The stop bit
   // hands off to push right after its sample so a following start bit
   // is not missed.
   always_comb begin
      w_rx_state_nx = r_rx_state;
      w_rx_cnt_nx   = r_rx_cnt;
      w_rx_sh_nx    = r_rx_sh;
      w_rx_bits_nx  = r_rx_bits;
      w_rx_zero_nx  = r_rx_zero;
      w_rx_perr_nx  = r_rx_perr;
      w_rx_ferr_nx  = r_rx_ferr;
      w_rx_brk_nx   = r_rx_brk;
      case (r_rx_state)
         RX_IDLE: begin
            if (enable && !srx_pad_i) begin
               w_rx_state_nx = RX_START;
               w_rx_cnt_nx   = '0;
               w_rx_sh_nx    = '0;
               w_rx_bits_nx  = '0;
               w_rx_zero_nx  = 1'b1;
               w_rx_perr_nx  = 1'b0;
               w_rx_ferr_nx  = 1'b0;
               w_rx_brk_nx   = 1'b0;
            end
         end
         RX_START: begin
            if (enable) begin
               if ((r_rx_cnt == 4'd7) && srx_pad_i) begin
                  w_rx_cnt_nx   = '0;
                  w_rx_state_nx = RX_IDLE;
               end else if (r_rx_cnt == 4'd15) begin
                  w_rx_cnt_nx   = '0;
                  w_rx_state_nx = RX_DATA;
               end else begin
                  w_rx_cnt_nx = r_rx_cnt + 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (enable) begin
               if (r_rx_cnt == 4'd7) begin
                  w_rx_sh_nx   = r_rx_sh | ({7'b0, srx_pad_i} << r_rx_bits);
                  w_rx_zero_nx = r_rx_zero & ~srx_pad_i;
               end
               if (r_rx_cnt == 4'd15) begin
                  w_rx_cnt_nx = '0;
                  if (r_rx_bits == w_last_bit) begin
                     w_rx_state_nx = lcr[3] ? RX_PAR : RX_STOP;
                  end else begin
                     w_rx_bits_nx = r_rx_bits + 3'd1;
                  end
               end else begin
                  w_rx_cnt_nx = r_rx_cnt + 4'd1;
               end
            end
         end
         RX_PAR: begin
            if (enable) begin
               if (r_rx_cnt == 4'd7) begin
                  w_rx_perr_nx = srx_pad_i ^ w_rx_exp_par;
                  w_rx_zero_nx = r_rx_zero & ~srx_pad_i;
               end
               if (r_rx_cnt == 4'd15) begin
                  w_rx_cnt_nx   = '0;
                  w_rx_state_nx = RX_STOP;
               end else begin
                  w_rx_cnt_nx = r_rx_cnt + 4'd1;
               end
            end
         end
         RX_STOP: begin
            if (enable) begin
               if (r_rx_cnt == 4'd7) begin
                  w_rx_ferr_nx  = ~srx_pad_i;
                  w_rx_brk_nx   = r_rx_zero & ~srx_pad_i;
                  w_rx_cnt_nx   = '0;
                  w_rx_state_nx = RX_PUSH;
               end else begin
                  w_rx_cnt_nx = r_rx_cnt + 4'd1;
               end
            end
         end
         RX_PUSH: begin
            w_rx_state_nx = RX_IDLE;
         end
         default: begin
            w_rx_cnt_nx   = '0;
            w_rx_state_nx = RX_IDLE;
         end
      endcase
   end

   assign rf_push = (r_rx_state == RX_PUSH);
   assign rstate  = r_rx_state;

   logic w_rf_store, w_rf_take, w_rf_drop;

   uart_txrx_fifo #(.WIDTH(11), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (wb_rst_ni),
      .i_clear (rx_reset),
      .i_push  (rf_push),
      .i_data  (w_rx_entry),
      .i_pop   (rf_pop),
      .o_head  (rf_data_out),
      .o_count (rf_count),
      .o_store (w_rf_store),
      .o_take  (w_rf_take),
      .o_drop  (w_rf_drop)
   );

   // Overrun: a drop in the same cycle as an LSR read stays visible.
   logic r_overrun;
   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni)     r_overrun <= 1'b0;
      else if (rx_reset)  r_overrun <= 1'b0;
      else if (w_rf_drop) r_overrun <= 1'b1;
      else if (lsr_mask)  r_overrun <= 1'b0;
   end
   assign rf_overrun = r_overrun;

   // Count of stored entries carrying a flag, so no FIFO scan is needed.
   logic [CNT_W-1:0] r_err_cnt;
   logic             w_in_err, w_head_err;
   assign w_in_err   = |w_rx_entry[2:0];
   assign w_head_err = |rf_data_out[2:0];

   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_err_cnt <= '0;
      end else if (rx_reset) begin
         r_err_cnt <= '0;
      end else begin
         case ({w_rf_store && w_in_err, w_rf_take && w_head_err})
            2'b10:   r_err_cnt <= r_err_cnt + 1'b1;
            2'b01:   r_err_cnt <= r_err_cnt - 1'b1;
            default: r_err_cnt <= r_err_cnt;
         endcase
      end
   end
   assign rf_error_bit = (r_err_cnt != '0);

   // Character timeout: four character times of 16 ticks per bit.
   logic [9:0] r_ct;
   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ct <= '0;
      end else if (rf_push || rf_pop || (rf_count == '0)) begin
         r_ct <= {w_char_bits, 6'b000000};
      end else if (enable && (r_ct != '0)) begin
         r_ct <= r_ct - 10'd1;
      end
   end
   assign counter_t = r_ct;

   logic w_unused;
   assign w_unused = ^{lcr[7], w_tf_store, w_tf_take, w_tf_drop};
endmodule

// File: tb/tb_uart_txrx_core.sv
// tb/tb_uart_txrx_core.sv - directed self-checking bench for uart_txrx_core

`timescale 1ns/1ps

module tb_uart_txrx_core;
   logic        clk = 1'b0;
   logic        wb_rst_ni;
   logic [7:0]  lcr;
   logic        enable;
   logic        tf_push;
   logic [7:0]  wb_dat_i;
   logic        tx_reset;
   logic        stx_pad_o;
   logic [2:0]  tstate;
   logic [4:0]  tf_count;
   logic        rf_pop;
   logic        srx_pad_i;
   logic        rx_reset;
   logic        lsr_mask;
   logic [9:0]  counter_t;
   logic [4:0]  rf_count;
   logic [10:0] rf_data_out;
   logic        rf_error_bit;
   logic        rf_overrun;
   logic [3:0]  rstate;
   logic        rf_push;

   logic loop_en;
   logic man_srx;
   assign srx_pad_i = loop_en ? stx_pad_o : man_srx;

   int checks = 0;
   int errors = 0;

   uart_txrx_core #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
      .clk          (clk),
      .wb_rst_ni    (wb_rst_ni),
      .lcr          (lcr),
      .enable       (enable),
      .tf_push      (tf_push),
      .wb_dat_i     (wb_dat_i),
      .tx_reset     (tx_reset),
      .stx_pad_o    (stx_pad_o),
      .tstate       (tstate),
      .tf_count     (tf_count),
      .rf_pop       (rf_pop),
      .srx_pad_i    (srx_pad_i),
      .rx_reset     (rx_reset),
      .lsr_mask     (lsr_mask),
      .counter_t    (counter_t),
      .rf_count     (rf_count),
      .rf_data_out  (rf_data_out),
      .rf_error_bit (rf_error_bit),
      .rf_overrun   (rf_overrun),
      .rstate       (rstate),
      .rf_push      (rf_push)
   );

   always #5 clk = ~clk;

   task automatic push_tx(input logic [7:0] d);
      tf_push  = 1'b1;
      wb_dat_i = d;
      @(negedge clk);
      tf_push  = 1'b0;
   endtask

   task automatic pop_rx();
      rf_pop = 1'b1;
      @(negedge clk);
      rf_pop = 1'b0;
   endtask

   task automatic pulse_rx_reset();
      rx_reset = 1'b1;
      @(negedge clk);
      rx_reset = 1'b0;
   endtask

   task automatic wait_rf_push(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (rf_push === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_tx_idle();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (tstate === 3'd0) break;
      end
   endtask

   task automatic drive_char(input logic [7:0] d, input int nb, input logic pen,
                             input logic pb, input logic sb);
      man_srx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         man_srx = d[i];
         repeat (16) @(negedge clk);
      end
      if (pen) begin
         man_srx = pb;
         repeat (16) @(negedge clk);
      end
      man_srx = sb;
      repeat (16) @(negedge clk);
      man_srx = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic test_reset();
      wb_rst_ni = 1'b0;
      lcr = 8'h00; enable = 1'b0; tf_push = 1'b0; wb_dat_i = 8'h00;
      tx_reset = 1'b0; rf_pop = 1'b0; rx_reset = 1'b0; lsr_mask = 1'b0;
      loop_en = 1'b0; man_srx = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (stx_pad_o !== 1'b1) begin errors++; $display("FAIL reset_stx got %b exp 1", stx_pad_o); end
      checks++; if (tstate !== 3'd0) begin errors++; $display("FAIL reset_tstate got %0d exp 0", tstate); end
      checks++; if (rstate !== 4'd0) begin errors++; $display("FAIL reset_rstate got %0d exp 0", rstate); end
      checks++; if (tf_count !== 5'd0 || rf_count !== 5'd0) begin errors++; $display("FAIL reset_counts got tf=%0d rf=%0d exp 0 0", tf_count, rf_count); end
      checks++; if (rf_overrun !== 1'b0 || rf_push !== 1'b0) begin errors++; $display("FAIL reset_flags got ovr=%b push=%b exp 0 0", rf_overrun, rf_push); end
      checks++; if (counter_t !== 10'd0) begin errors++; $display("FAIL reset_counter_t got %0d exp 0", counter_t); end
      checks++; if (rf_data_out !== 11'h000 || rf_error_bit !== 1'b0) begin errors++; $display("FAIL reset_rx_head got %h err=%b exp 000 0", rf_data_out, rf_error_bit); end
      wb_rst_ni = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_tx_fifo();
      enable = 1'b0;
      push_tx(8'h11);
      checks++; if (tf_count !== 5'd1) begin errors++; $display("FAIL txfifo_one got %0d exp 1", tf_count); end
      repeat (4) @(negedge clk);
      checks++; if (tstate !== 3'd0 || stx_pad_o !== 1'b1) begin errors++; $display("FAIL no_enable_hold got tstate=%0d stx=%b exp 0 1", tstate, stx_pad_o); end
      for (int i = 0; i < 16; i++) push_tx(8'(i));
      checks++; if (tf_count !== 5'd16) begin errors++; $display("FAIL txfifo_full got %0d exp 16", tf_count); end
      tx_reset = 1'b1;
      @(negedge clk);
      tx_reset = 1'b0;
      checks++; if (tf_count !== 5'd0) begin errors++; $display("FAIL tx_reset got %0d exp 0", tf_count); end
   endtask

   task automatic test_tx_frame();
      logic [9:0] exp_bits;
      bit         found;
      exp_bits = {1'b1, 8'h55, 1'b0};
      lcr = 8'h03; enable = 1'b1; loop_en = 1'b0; man_srx = 1'b1;
      push_tx(8'h55);
      checks++; if (tf_count !== 5'd1) begin errors++; $display("FAIL tx_count_pushed got %0d exp 1", tf_count); end
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stx_pad_o === 1'b0) begin found = 1'b1; break; end
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL tx_start_seen got %b exp 1", found); end
      checks++; if (tf_count !== 5'd0 || tstate !== 3'd1) begin errors++; $display("FAIL tx_popped got cnt=%0d tstate=%0d exp 0 1", tf_count, tstate); end
      for (int i = 0; i < 10; i++) begin
         if (i == 0) repeat (8) @(negedge clk);
         else repeat (16) @(negedge clk);
         checks++; if (stx_pad_o !== exp_bits[i]) begin errors++; $display("FAIL tx_bit%0d got %b exp %b", i, stx_pad_o, exp_bits[i]); end
      end
      checks++; if (tstate !== 3'd4) begin errors++; $display("FAIL tx_in_stop got %0d exp 4", tstate); end
      repeat (10) @(negedge clk);
      checks++; if (tstate !== 3'd0 || stx_pad_o !== 1'b1) begin errors++; $display("FAIL tx_back_idle got tstate=%0d stx=%b exp 0 1", tstate, stx_pad_o); end
   endtask

   task automatic test_rx_loopback();
      bit ok;
      lcr = 8'h1B; loop_en = 1'b1;
      push_tx(8'hA5);
      wait_rf_push(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL loop_rf_push got %b exp 1", ok); end
      @(negedge clk);
      checks++; if (rf_push !== 1'b0) begin errors++; $display("FAIL loop_push_width got %b exp 0", rf_push); end
      checks++; if (rf_count !== 5'd1) begin errors++; $display("FAIL loop_count got %0d exp 1", rf_count); end
      checks++; if (rf_data_out !== 11'h528) begin errors++; $display("FAIL loop_data got %h exp 528", rf_data_out); end
      checks++; if (rf_error_bit !== 1'b0) begin errors++; $display("FAIL loop_err_bit got %b exp 0", rf_error_bit); end
      wait_tx_idle();
      loop_en = 1'b0; man_srx = 1'b1;
      pop_rx();
      checks++; if (rf_count !== 5'd0 || rf_data_out !== 11'h000) begin errors++; $display("FAIL loop_pop got cnt=%0d data=%h exp 0 000", rf_count, rf_data_out); end
   endtask

   task automatic test_parity_error();
      lcr = 8'h1B;
      drive_char(8'h3C, 8, 1'b1, 1'b1, 1'b1);
      checks++; if (rf_count !== 5'd1) begin errors++; $display("FAIL par_count got %0d exp 1", rf_count); end
      checks++; if (rf_data_out !== 11'h1E2) begin errors++; $display("FAIL par_entry got %h exp 1e2", rf_data_out); end
      checks++; if (rf_error_bit !== 1'b1) begin errors++; $display("FAIL par_err_bit got %b exp 1", rf_error_bit); end
      pop_rx();
      checks++; if (rf_count !== 5'd0 || rf_error_bit !== 1'b0) begin errors++; $display("FAIL par_pop got cnt=%0d err=%b exp 0 0", rf_count, rf_error_bit); end
   endtask

   task automatic test_break();
      lcr = 8'h1B;
      man_srx = 1'b0;
      repeat (12 * 16) @(negedge clk);
      man_srx = 1'b1;
      repeat (15 * 16) @(negedge clk);
      checks++; if (rf_data_out !== 11'h005) begin errors++; $display("FAIL break_entry got %h exp 005", rf_data_out); end
      checks++; if (rf_error_bit !== 1'b1) begin errors++; $display("FAIL break_err_bit got %b exp 1", rf_error_bit); end
      pulse_rx_reset();
      checks++; if (rf_count !== 5'd0 || rf_error_bit !== 1'b0) begin errors++; $display("FAIL break_flush got cnt=%0d err=%b exp 0 0", rf_count, rf_error_bit); end
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      lcr = 8'h1B;
      for (int i = 0; i < 17; i++) begin
         d = 8'h10 + 8'(i);
         drive_char(d, 8, 1'b1, ^d, 1'b1);
      end
      checks++; if (rf_count !== 5'd16) begin errors++; $display("FAIL ovr_count got %0d exp 16", rf_count); end
      checks++; if (rf_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", rf_overrun); end
      checks++; if (rf_data_out !== 11'h080 || rf_error_bit !== 1'b0) begin errors++; $display("FAIL ovr_head got %h err=%b exp 080 0", rf_data_out, rf_error_bit); end
      lsr_mask = 1'b1;
      @(negedge clk);
      lsr_mask = 1'b0;
      checks++; if (rf_overrun !== 1'b0 || rf_count !== 5'd16) begin errors++; $display("FAIL ovr_clear got ovr=%b cnt=%0d exp 0 16", rf_overrun, rf_count); end
      pulse_rx_reset();
      checks++; if (rf_count !== 5'd0) begin errors++; $display("FAIL ovr_flush got %0d exp 0", rf_count); end
   endtask

   task automatic test_timeout();
      bit ok;
      lcr = 8'h03;
      repeat (2) @(negedge clk);
      checks++; if (counter_t !== 10'd640) begin errors++; $display("FAIL ct_empty_reload got %0d exp 640", counter_t); end
      loop_en = 1'b1;
      push_tx(8'h3A);
      wait_rf_push(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ct_rf_push got %b exp 1", ok); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (counter_t !== 10'd640 || rf_count !== 5'd1) begin errors++; $display("FAIL ct_reload got ct=%0d cnt=%0d exp 640 1", counter_t, rf_count); end
      checks++; if (rf_data_out !== 11'h1D0) begin errors++; $display("FAIL ct_data got %h exp 1d0", rf_data_out); end
      repeat (639) @(negedge clk);
      checks++; if (counter_t !== 10'd1) begin errors++; $display("FAIL ct_before_zero got %0d exp 1", counter_t); end
      @(negedge clk);
      checks++; if (counter_t !== 10'd0) begin errors++; $display("FAIL ct_zero got %0d exp 0", counter_t); end
      repeat (5) @(negedge clk);
      checks++; if (counter_t !== 10'd0) begin errors++; $display("FAIL ct_saturate got %0d exp 0", counter_t); end
      pulse_rx_reset();
      checks++; if (rf_count !== 5'd0) begin errors++; $display("FAIL ct_rx_reset got %0d exp 0", rf_count); end
      @(negedge clk);
      checks++; if (counter_t !== 10'd640) begin errors++; $display("FAIL ct_after_flush got %0d exp 640", counter_t); end
      loop_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tx_fifo();
      test_tx_frame();
      test_rx_loopback();
      test_parity_error();
      test_break();
      test_overrun();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
endmodule
